// File: rtl/fifo.sv
// fifo: single-clock byte FIFO with registered read data, occupancy count and full/empty flags
module fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_empty,
    output logic              buf_full,
    output logic [CNT_W-1:0]  fifo_counter
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              wr_acc, rd_acc;
    always_comb begin
        buf_empty    = count == '0;
        buf_full     = count == CNT_W'(DEPTH);
        wr_acc       = wr_en && !buf_full;
        rd_acc       = rd_en && !buf_empty;
        fifo_counter = count;
    end
    always_ff @(posedge clk)
        if (wr_acc) mem[wr_ptr] <= buf_in;
    // read uses the pre-edge rd_ptr, so a same-cycle write is never bypassed
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            buf_out <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                buf_out <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed plan plus random traffic checked against a queue-based model
module tb_fifo;
    logic       clk = 0, rst = 1, wr_en = 0, rd_en = 0;
    logic [7:0] buf_in = 0, buf_out, fifo_counter;
    logic       buf_empty, buf_full;
    int         checks = 0, errors = 0;
    logic [7:0] q[$];
    logic [7:0] m_out = 0;

    fifo dut (
        .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
        .buf_out(buf_out), .buf_empty(buf_empty), .buf_full(buf_full),
        .fifo_counter(fifo_counter)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare();
        check("buf_out", 32'(buf_out), 32'(m_out));
        check("count", 32'(fifo_counter), q.size());
        check("empty", 32'(buf_empty), 32'(q.size() == 0));
        check("full", 32'(buf_full), 32'(q.size() == 64));
    endtask

    task automatic step(bit w, bit r, logic [7:0] d);
        bit full, empty;
        @(negedge clk);
        wr_en = w; rd_en = r; buf_in = d;
        @(posedge clk);
        full  = q.size() == 64;
        empty = q.size() == 0;
        if (r && !empty) m_out = q.pop_front();
        if (w && !full) q.push_back(d);
        #1 compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 0; rd_en = 0;
        #2 rst = 1;
        q.delete();
        m_out = 0;
        #1 compare();
        @(negedge clk) rst = 0;
    endtask

    initial begin
        int exp_pop[5] = '{2, 10, 20, 30, 40};
        do_reset();
        step(1, 0, 1);
        check("plan_cnt1", 32'(fifo_counter), 1);
        check("plan_nonempty", 32'(buf_empty), 0);
        step(1, 1, 2);
        check("plan_same_cycle", 32'(buf_out), 1);
        check("plan_cnt_hold", 32'(fifo_counter), 1);
        for (int k = 1; k <= 13; k++) step(1, 0, 8'(10 * k));
        check("plan_cnt14", 32'(fifo_counter), 14);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0);
            check("plan_order", 32'(buf_out), exp_pop[i]);
        end
        while (q.size() < 64) step(1, 0, 8'($urandom));
        check("plan_full", 32'(buf_full), 1);
        step(1, 0, 140);
        check("plan_full_ignore", 32'(fifo_counter), 64);
        step(0, 1, 0);
        check("plan_not_140", 32'(buf_out == 140 && m_out != 140), 0);
        step(1, 0, 8'($urandom));
        step(1, 1, 77);
        check("plan_both_full", 32'(fifo_counter), 63);
        while (q.size() != 0) step(0, 1, 0);
        step(0, 1, 0);
        check("plan_empty_hold_cnt", 32'(fifo_counter), 0);
        step(1, 1, 9);
        check("plan_empty_both_cnt", 32'(fifo_counter), 1);
        step(0, 1, 0);
        step(1, 0, 5);
        step(0, 1, 0);
        check("plan_pop5", 32'(buf_out), 5);
        check("plan_pop5_empty", 32'(buf_empty), 1);
        for (int i = 0; i < 100; i++) step(1, 1'($urandom_range(0, 1)), 8'(i));
        for (int i = 0; i < 400; i++) begin
            int bias = (i / 100) % 2 ? 3 : 1;
            step($urandom_range(0, 3) < bias, $urandom_range(0, 3) >= bias, 8'($urandom));
        end
        for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom));
        step(1, 1, 8'($urandom));
        do_reset();
        check("mid_reset_cnt", 32'(fifo_counter), 0);
        for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo.md
# fifo

Single-clock synchronous FIFO buffering 8-bit bytes between a producer and a consumer in the same clock domain. Writes and reads are single-cycle strobes gated internally by full/empty status. The block exposes an occupancy count and full/empty flags so upstream and downstream logic can throttle themselves. Read data is registered and appears on `buf_out` on the clock edge that performs the read.

## Interface
- `DATA_W`, default 8: data width in bits.
- `ADDR_W`, default 6: pointer width; storage depth is 2^ADDR_W = 64 entries.
- `CNT_W`, default 8: width of `fifo_counter`; must be ≥ ADDR_W+1.

Ports:
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  reset, asynchronous and active-high.
- `buf_in`  in  DATA_W  write data, sampled when a write is accepted.
- `wr_en`  in  1  write request strobe.
- `rd_en`  in  1  read request strobe.
- `buf_out`  out  DATA_W  registered read data.
- `buf_empty`  out  1  high when occupancy = 0.
- `buf_full`  out  1  high when occupancy = 2^ADDR_W.
- `fifo_counter`  out  CNT_W  current occupancy, zero-extended.

## Operation
- Storage is a 2^ADDR_W × DATA_W array, with write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_W bits.
- Pointers wrap naturally modulo 2^ADDR_W.
- Write accepted: `wr_acc` = `wr_en` & !`buf_full`.
  - On accept, store `buf_in` at `mem[wr_ptr]` and increment `wr_ptr`.
- Read accepted: `rd_acc` = `rd_en` & !`buf_empty`.
  - On accept, `buf_out` <= `mem[rd_ptr]` and increment `rd_ptr`.
- `buf_out` holds its previous value whenever no read is accepted.
- Occupancy update per edge:
  - both accepted: unchanged;
  - only write accepted: +1;
  - only read accepted: −1;
  - otherwise: unchanged.
- Flags are decoded combinationally from the occupancy register: `buf_empty` = (count==0), `buf_full` = (count==2^ADDR_W).
- Write while full is ignored: no storage change, no pointer change, no count change.
- Read while empty is ignored: `buf_out` holds, no pointer change, no count change.
- Simultaneous wr_en & rd_en:
  - Empty: only the write is accepted; the count goes 0→1 and `buf_out` is unchanged. There is no bypass.
  - Full: only the read is accepted; the count goes 64→63.
  - Otherwise: both are accepted, the count is unchanged, and `buf_out` receives the oldest entry. The read uses `rd_ptr` before the write lands, so it never returns the same-cycle write data unless that entry was already present.
- Data order is strictly first-in first-out.
- Reset (asynchronous assert, any time, including mid-operation):
  - `wr_ptr`, `rd_ptr`, count and `buf_out` are cleared to 0.
  - `buf_empty` = 1, `buf_full` = 0, `fifo_counter` = 0.
  - Memory contents are not cleared; they are don't-care.

## Timing
- All state updates occur on the rising edge of `clk` while `rst` is low.
- Read latency is one edge: `buf_out` is valid immediately after the edge where `rd_acc` = 1.
- Write-to-read latency: data written at edge N is readable by a read accepted at edge N+1 or later.
- Flags and `fifo_counter` reflect the post-edge count in the same cycle; there is no extra delay.
- Strobes are level-sampled: an `wr_en`/`rd_en` held high for k edges performs k operations, each subject to full/empty gating.
- Inputs must meet setup and hold to `clk`. Reset deassertion is assumed synchronous to `clk` by the surrounding logic.

## Test plan
- Reset, then push 1 -> `fifo_counter` = 1, `buf_empty` = 0. Push 2 and pop in the same cycle -> `buf_out` = 1 and `fifo_counter` stays 1.
- Push 10, 20, …, 130 (13 pushes) -> `fifo_counter` = 14. Pops then return 2, 10, 20, 30, 40 in order.
- Fill to 64 entries -> `buf_full` = 1. A further push of 140 is ignored with count 64; the next pop returns the oldest entry, not 140.
- At full, assert `wr_en` and `rd_en` together -> count becomes 63 and `buf_out` = oldest entry.
- Drain to empty, then pop -> `buf_out` holds its last value and count stays 0. Push 5 then pop -> `buf_out` = 5 and `buf_empty` = 1.
- Push 100 entries with interleaved pops so the pointers wrap past 63 -> data order is preserved. Assert `rst` mid-stream, off-edge -> the outputs clear immediately.
